// File: rtl/cop0_unit_pkg.sv
// Shared constants for the coprocessor-0 unit: register indices, exception codes,
// field positions, instruction encodings and the trap FSM state type.
package cop0_unit_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LO  = 10;
    localparam int ST_IM_HI  = 15;

    localparam logic [5:0] OP_COP0    = 6'b010000;
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;
    localparam logic [4:0] RS_MTC0    = 5'b00100;
    localparam logic [4:0] RS_ERET    = 5'b10000;
    localparam logic [1:0] COPWR_ACT  = 2'b01;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_TRAP = 1'b1
    } cop0_state_e;

endpackage

// File: rtl/cop0_int_sync.sv
// Multi-flop synchroniser for the six asynchronous external interrupt lines.
module cop0_int_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] i_async,
    output logic [5:0] o_sync
);

    logic [SYNC_STAGES-1:0][5:0] r_sync;

    // NOTE: non-blocking assignments so each stage captures the previous stage's old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/cop0_unit.sv
// Coprocessor-0: Status/Cause/EPC/PRId, MTC0/MFC0/SYSCALL/ERET and a registered PC redirect.
// Optional Count/Compare timer is built when COP0_TIMER_EN is defined.
module cop0_unit
    import cop0_unit_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080,
    parameter logic [31:0] PRID         = 32'h0000_0001,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid,
    input  logic [31:0] ins,
    input  logic [1:0]  copWr,
    input  logic [31:0] pc,
    input  logic [31:0] rt_data,
    input  logic [5:0]  hw_int,
    output logic [31:0] cop_rdata,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    cop0_state_e r_state, w_state_nxt;

    logic        r_ie, r_exl;
    logic [5:0]  r_im;
    logic [4:0]  r_exc_code;
    logic [31:0] r_epc, r_redirect_pc;

    logic [5:0]  w_hw_sync, w_ip;
    logic [31:0] w_count, w_compare;
    logic [5:0]  w_op, w_func;
    logic [4:0]  w_rs, w_rd;
    logic        w_cop_act, w_is_mtc0, w_is_eret, w_is_syscall;
    logic        w_accept, w_int_req, w_take_int, w_take_sys, w_take_eret, w_trap, w_mtc0_we;
    logic        w_unused_bits;

    cop0_int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_int_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (hw_int),
        .o_sync  (w_hw_sync)
    );

    assign w_op   = ins[31:26];
    assign w_rs   = ins[25:21];
    assign w_rd   = ins[15:11];
    assign w_func = ins[5:0];

    assign w_cop_act    = (copWr == COPWR_ACT);
    assign w_is_mtc0    = w_cop_act && (w_op == OP_COP0) && (w_rs == RS_MTC0);
    assign w_is_eret    = w_cop_act && (w_op == OP_COP0) && (w_rs == RS_ERET);
    assign w_is_syscall = w_cop_act && (w_op == OP_SPECIAL) && (w_func == FN_SYSCALL);

    // Interrupt outranks SYSCALL outranks ERET; a taken trap also cancels a coincident MTC0.
    assign w_accept    = (r_state == S_RUN) && inst_valid;
    assign w_int_req   = r_ie && !r_exl && |(w_ip & r_im);
    assign w_take_int  = w_accept && w_int_req;
    assign w_take_sys  = w_accept && !w_int_req && w_is_syscall;
    assign w_take_eret = w_accept && !w_int_req && !w_is_syscall && w_is_eret;
    assign w_trap      = w_take_int || w_take_sys || w_take_eret;
    assign w_mtc0_we   = w_accept && w_is_mtc0 && !w_trap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        flush       = 1'b0;
        redirect    = 1'b0;
        case (r_state)
            S_RUN: begin
                flush = w_take_int;
                if (w_trap) w_state_nxt = S_TRAP;
            end
            S_TRAP: begin
                redirect    = 1'b1;
                w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ie          <= 1'b0;
            r_exl         <= 1'b0;
            r_im          <= '0;
            r_exc_code    <= '0;
            r_epc         <= '0;
            r_redirect_pc <= '0;
        end else begin
            if (w_mtc0_we) begin
                case (w_rd)
                    REG_STATUS: begin
                        r_ie  <= rt_data[ST_IE];
                        r_exl <= rt_data[ST_EXL];
                        r_im  <= rt_data[ST_IM_HI:ST_IM_LO];
                    end
                    REG_EPC: r_epc <= rt_data;
                    default: ;
                endcase
            end
            if (w_take_int || w_take_sys) begin
                r_epc         <= pc;
                r_exc_code    <= w_take_int ? EXC_INT : EXC_SYS;
                r_exl         <= 1'b1;
                r_redirect_pc <= HANDLER_ADDR;
            end else if (w_take_eret) begin
                r_exl         <= 1'b0;
                r_redirect_pc <= r_epc;
            end
        end
    end

`ifdef COP0_TIMER_EN
    logic [31:0] r_count, r_compare;
    logic        r_timer_pend, r_timer_armed;

    // The armed flop keeps the Count==Compare==0 state right after reset from firing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count       <= '0;
            r_compare     <= '0;
            r_timer_pend  <= 1'b0;
            r_timer_armed <= 1'b0;
        end else begin
            r_timer_armed <= 1'b1;
            if (w_mtc0_we && (w_rd == REG_COUNT)) r_count <= rt_data;
            else                                  r_count <= r_count + 32'd1;
            if (w_mtc0_we && (w_rd == REG_COMPARE)) begin
                r_compare    <= rt_data;
                r_timer_pend <= 1'b0;
            end else if (r_timer_armed && (r_count == r_compare)) begin
                r_timer_pend <= 1'b1;
            end
        end
    end

    assign w_count       = r_count;
    assign w_compare     = r_compare;
    assign w_ip          = {r_timer_pend, w_hw_sync[4:0]};
    assign w_unused_bits = ^{ins[20:6], w_hw_sync[5]};
`else
    assign w_count       = '0;
    assign w_compare     = '0;
    assign w_ip          = w_hw_sync;
    assign w_unused_bits = ^ins[20:6];
`endif

    always_comb begin
        cop_rdata = '0;
        case (w_rd)
            REG_COUNT:   cop_rdata = w_count;
            REG_COMPARE: cop_rdata = w_compare;
            REG_STATUS:  cop_rdata = {16'd0, r_im, 8'd0, r_exl, r_ie};
            REG_CAUSE:   cop_rdata = {16'd0, w_ip, 3'd0, r_exc_code, 2'd0};
            REG_EPC:     cop_rdata = r_epc;
            REG_PRID:    cop_rdata = PRID;
            default:     cop_rdata = '0;
        endcase
    end

    assign redirect_pc = r_redirect_pc;

endmodule

// File: tb/tb_cop0_unit.sv
// Self-checking bench for cop0_unit: register table, trap sequences, sync latency, reset mid-trap.
module tb_cop0_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_valid = 1'b0;
    logic [31:0] ins = '0;
    logic [1:0]  cop_wr = '0;
    logic [31:0] pc = '0;
    logic [31:0] rt_data = '0;
    logic [5:0]  hw_int = '0;
    logic [31:0] cop_rdata;
    logic        flush, redirect;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] SYSCALL_I = 32'h0000_000C;
    localparam logic [31:0] ERET_I    = 32'h4200_0018;
    localparam logic [31:0] NOP_I     = 32'h0000_0000;

    always #5 clk = ~clk;

    cop0_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst_valid  (inst_valid),
        .ins         (ins),
        .copWr       (cop_wr),
        .pc          (pc),
        .rt_data     (rt_data),
        .hw_int      (hw_int),
        .cop_rdata   (cop_rdata),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    typedef struct {
        logic [31:0] ins;
        logic [1:0]  cop_wr;
        logic        valid;
        logic [31:0] rt;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[17];

    function automatic logic [31:0] f_mtc0(input logic [4:0] rd);
        return {6'b010000, 5'b00100, 5'd0, rd, 11'd0};
    endfunction

    function automatic logic [31:0] f_mfc0(input logic [4:0] rd);
        return {6'b010000, 5'b00000, 5'd0, rd, 11'd0};
    endfunction

    function automatic vec_t mk(input logic [31:0] i, input logic [1:0] cw, input logic v,
                                input logic [31:0] rt, input logic [31:0] exp);
        vec_t t;
        t.ins = i; t.cop_wr = cw; t.valid = v; t.rt = rt; t.exp_rdata = exp;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic [1:0] cw, input logic v,
                         input logic [31:0] p, input logic [31:0] rt);
        ins = i; cop_wr = cw; inst_valid = v; pc = p; rt_data = rt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input logic [4:0] rd, input string name, input logic [31:0] exp);
        drive(f_mfc0(rd), 2'b00, 1'b0, pc, 32'd0);
        #1;
        check(name, cop_rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(f_mtc0(12), 2'b01, 1'b1, 32'h0000_FC03, 32'h0000_0000);
        vecs[1]  = mk(f_mfc0(12), 2'b00, 1'b1, 32'h0,         32'h0000_FC03);
        vecs[2]  = mk(f_mtc0(13), 2'b01, 1'b1, 32'h0000_FFFF, 32'h0000_0000);
        vecs[3]  = mk(f_mfc0(13), 2'b00, 1'b1, 32'h0,         32'h0000_0000);
        vecs[4]  = mk(f_mtc0(14), 2'b01, 1'b1, 32'h1234_5678, 32'h0000_0000);
        vecs[5]  = mk(f_mfc0(14), 2'b00, 1'b1, 32'h0,         32'h1234_5678);
        vecs[6]  = mk(f_mtc0(15), 2'b01, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
        vecs[7]  = mk(f_mfc0(15), 2'b00, 1'b1, 32'h0,         32'h0000_0001);
        vecs[8]  = mk(f_mtc0(3),  2'b01, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000);
        vecs[9]  = mk(f_mfc0(3),  2'b00, 1'b1, 32'h0,         32'h0000_0000);
        vecs[10] = mk(f_mtc0(12), 2'b01, 1'b0, 32'h0,         32'h0000_FC03);
        vecs[11] = mk(f_mtc0(12), 2'b10, 1'b1, 32'h0,         32'h0000_FC03);
        vecs[12] = mk(f_mfc0(12), 2'b00, 1'b1, 32'h0,         32'h0000_FC03);
        vecs[13] = mk(f_mtc0(12), 2'b01, 1'b1, 32'hFFFF_FFFF, 32'h0000_FC03);
        vecs[14] = mk(f_mfc0(12), 2'b00, 1'b1, 32'h0,         32'h0000_FC03);
        vecs[15] = mk(f_mtc0(12), 2'b01, 1'b1, 32'h0,         32'h0000_FC03);
        vecs[16] = mk(f_mfc0(12), 2'b00, 1'b1, 32'h0,         32'h0000_0000);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_redirect", {31'd0, redirect}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        rd_chk(12, "rst_status", 32'd0);
        rd_chk(13, "rst_cause", 32'd0);
        rd_chk(14, "rst_epc", 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Register access table
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].ins, vecs[i].cop_wr, vecs[i].valid, 32'h1000 + 32'(i * 4), vecs[i].rt);
            #1;
            check($sformatf("vec%0d_rdata", i), cop_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_flush", i), {31'd0, flush}, 32'd0);
            tick();
            check($sformatf("vec%0d_redirect", i), {31'd0, redirect}, 32'd0);
        end

        // SYSCALL, then a SYSCALL offered during TRAP must be ignored
        drive(SYSCALL_I, 2'b01, 1'b1, 32'h40, 32'd0);
        #1;
        check("sys_flush", {31'd0, flush}, 32'd0);
        tick();
        check("sys_redirect", {31'd0, redirect}, 32'd1);
        check("sys_redirect_pc", redirect_pc, 32'h80);
        rd_chk(14, "sys_epc", 32'h40);
        rd_chk(13, "sys_cause", 32'h20);
        rd_chk(12, "sys_status", 32'h2);
        drive(SYSCALL_I, 2'b01, 1'b1, 32'h44, 32'd0);
        tick();
        check("trap_no_repeat", {31'd0, redirect}, 32'd0);
        rd_chk(14, "trap_ignored_epc", 32'h40);

        // ERET back to EPC
        drive(ERET_I, 2'b01, 1'b1, 32'h48, 32'd0);
        #1;
        check("eret_flush", {31'd0, flush}, 32'd0);
        tick();
        check("eret_redirect", {31'd0, redirect}, 32'd1);
        check("eret_redirect_pc", redirect_pc, 32'h40);
        rd_chk(12, "eret_status", 32'd0);
        tick();

        // Interrupt through the two-stage synchroniser
        drive(f_mtc0(12), 2'b01, 1'b1, 32'h4C, 32'h0000_0401);
        tick();
        hw_int = 6'b000001;
        drive(NOP_I, 2'b00, 1'b1, 32'hF8, 32'd0);
        #1;
        check("int_sync0_flush", {31'd0, flush}, 32'd0);
        tick();
        drive(NOP_I, 2'b00, 1'b1, 32'hFC, 32'd0);
        #1;
        check("int_sync1_flush", {31'd0, flush}, 32'd0);
        tick();
        rd_chk(13, "int_cause_pending", 32'h420);
        drive(NOP_I, 2'b00, 1'b1, 32'h100, 32'd0);
        #1;
        check("int_flush", {31'd0, flush}, 32'd1);
        tick();
        check("int_redirect", {31'd0, redirect}, 32'd1);
        check("int_redirect_pc", redirect_pc, 32'h80);
        rd_chk(14, "int_epc", 32'h100);
        rd_chk(13, "int_cause", 32'h400);
        rd_chk(12, "int_status", 32'h403);
        tick();

        // In handler: EXL masks a new interrupt; ERET then lets it through
        drive(f_mtc0(12), 2'b01, 1'b1, 32'h80, 32'h0000_0C03);
        tick();
        hw_int = 6'b000011;
        for (int k = 0; k < 3; k++) begin
            drive(NOP_I, 2'b00, 1'b1, 32'h84 + 32'(k * 4), 32'd0);
            #1;
            check($sformatf("exl_mask_flush%0d", k), {31'd0, flush}, 32'd0);
            tick();
        end
        check("exl_mask_redirect", {31'd0, redirect}, 32'd0);
        rd_chk(13, "exl_mask_cause", 32'hC00);
        drive(ERET_I, 2'b01, 1'b1, 32'h90, 32'd0);
        #1;
        check("h_eret_flush", {31'd0, flush}, 32'd0);
        tick();
        check("h_eret_redirect_pc", redirect_pc, 32'h100);
        rd_chk(12, "h_eret_status", 32'hC01);
        tick();
        drive(NOP_I, 2'b00, 1'b1, 32'h100, 32'd0);
        #1;
        check("pending_int_flush", {31'd0, flush}, 32'd1);
        tick();
        check("pending_int_redirect", {31'd0, redirect}, 32'd1);
        rd_chk(14, "pending_int_epc", 32'h100);
        tick();

        // Interrupt and SYSCALL in the same cycle
        drive(ERET_I, 2'b01, 1'b1, 32'h84, 32'd0);
        tick();
        tick();
        drive(SYSCALL_I, 2'b01, 1'b1, 32'h104, 32'd0);
        #1;
        check("int_sys_flush", {31'd0, flush}, 32'd1);
        tick();
        check("int_sys_redirect_pc", redirect_pc, 32'h80);
        rd_chk(13, "int_sys_cause", 32'hC00);
        rd_chk(14, "int_sys_epc", 32'h104);
        tick();

        // MTC0 EPC coinciding with an interrupt: trap value wins
        drive(ERET_I, 2'b01, 1'b1, 32'h84, 32'd0);
        tick();
        tick();
        drive(f_mtc0(14), 2'b01, 1'b1, 32'h200, 32'hDEAD_BEEF);
        #1;
        check("int_mtc0_flush", {31'd0, flush}, 32'd1);
        tick();
        check("int_mtc0_redirect", {31'd0, redirect}, 32'd1);
        rd_chk(14, "int_mtc0_epc", 32'h200);

        // Asynchronous reset during TRAP
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_trap_redirect", {31'd0, redirect}, 32'd0);
        check("rst_trap_redirect_pc", redirect_pc, 32'd0);
        rd_chk(12, "rst_trap_status", 32'd0);
        rd_chk(14, "rst_trap_epc", 32'd0);
        hw_int = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

`ifdef COP0_TIMER_EN
        begin
            int waited;
            waited = 0;
            drive(f_mtc0(11), 2'b01, 1'b1, 32'h300, 32'd20);
            tick();
            drive(f_mtc0(9), 2'b01, 1'b1, 32'h304, 32'd0);
            tick();
            drive(f_mfc0(13), 2'b00, 1'b0, 32'h308, 32'd0);
            while (waited < 40 && !cop_rdata[15]) begin
                tick();
                waited++;
            end
            check("timer_match_cycles", 32'(waited), 32'd21);
            drive(f_mtc0(11), 2'b01, 1'b1, 32'h30C, 32'd1000);
            tick();
            rd_chk(13, "timer_clear_cause", 32'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
